pool_window_gen: RTL
====================

Name: pool_window_gen

Overview:
- Streaming producer of 2x2 non-overlapping (stride-2) windows for the max-pool comparator.
- Accepts a raster-ordered feature map one pixel per beat and buffers one even row.
- Emits a 2x2 window when each odd-row/odd-column pixel arrives.
- Sits between the conv/ReLU output stream and the comparator's 2x2 input.

Parameters:
- DATA_WIDTH, from cnn_defs.svh (8): pixel width.
- IMG_WIDTH, 8: pixels per row; must be >= 2.
- IMG_HEIGHT, 8: rows per frame; must be >= 2.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- pix_in  input  DATA_WIDTH  input pixel, raster order.
- pix_valid  input  1  pix_in valid.
- pix_ready  output  1  block can accept pix_in this cycle.
- win_out  output  DATA_WIDTH x [1:0][1:0]  window: [0][0] top-left, [0][1] top-right, [1][0] bottom-left, [1][1] bottom-right.
- win_valid  output  1  win_out holds a valid window.
- win_ready  input  1  downstream accepts win_out this cycle.
- frame_done  output  1  one-cycle pulse when the last window of a frame is accepted.

Behaviour:
- Reset: all outputs 0 except pix_ready; pix_ready = 1 after reset. Counters zeroed, FSM in S_EVEN, output register empty. Line buffer contents are don't-care.
- Input beat: a pixel is accepted when pix_valid && pix_ready.
- pix_ready = !win_valid || win_ready. The input stalls only while a window is pending and not being taken.
- Counters: col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) advance per accepted beat. col wraps to 0 and row increments at IMG_WIDTH-1. row wraps to 0 at the end of the frame.
- FSM states:
  - S_EVEN: row even. Write pixel to line_buf[col]. Go to S_ODD at end of row.
  - S_ODD: row odd. On even col, latch pixel into left_reg. On odd col, load the output register with {line_buf[col-1], line_buf[col], left_reg, pix_in} and set win_valid. Go to S_EVEN at end of row.
- Odd width: the trailing column is accepted but ignored; no window is produced for it.
- Odd height: the final (even) row is accepted into line_buf but produces no windows. frame_done fires on the last window of the preceding odd row.
- Latency: win_valid rises on the cycle after the bottom-right pixel is accepted.
- Window hold: win_valid stays high, with win_out stable, until win_ready is sampled high.
- Simultaneous events: accept and window-load in the same cycle are allowed (win_valid && win_ready && new window pixel). The register reloads and win_valid stays 1.
- frame_done: asserted for one cycle on acceptance of the window with row == last odd row and col == last odd column. Independent of whether the next frame's pixels are already streaming.
- Back-to-back frames: supported with no idle cycles. The next frame begins at row 0 in S_EVEN immediately.
- Reset mid-frame: the partial frame is discarded, no frame_done is issued, and the next accepted pixel is treated as (row 0, col 0).
- Window count per frame: floor(IMG_WIDTH/2) * floor(IMG_HEIGHT/2).

Optional Feature:
- Macro: POOL_WINDOW_POS_EN.
- When defined: add outputs win_row and win_col, each clog2(max(IMG_WIDTH, IMG_HEIGHT)/2 + 1) bits wide. They give the pooled-output coordinates of win_out, are registered with win_out, and reset to 0.
- When undefined: these ports and their logic are absent. All other behaviour is identical.

Test Plan:
- 4x4 frame, pixels 1..16, win_ready = 1 -> windows {1,2,5,6}, {3,4,7,8}, {9,10,13,14}, {11,12,15,16} in order; frame_done pulses once, with the 4th window.
- Same frame, win_ready held low 5 cycles when the first window appears -> win_out stays {1,2,5,6}; pix_ready = 0 from the first blocked beat; no pixel lost; sequence unchanged.
- IMG_WIDTH = 5, IMG_HEIGHT = 3, pixels 1..15 -> exactly 2 windows: {1,2,6,7}, {3,4,8,9}; column 5 and row 3 ignored; frame_done on the 2nd window.
- Reset asserted after 6 pixels of a 4x4 frame, then a full frame 101..116 -> first window {101,102,105,106}; no frame_done before the 4th new window.
- Two back-to-back 4x4 frames with random win_ready -> 8 windows, 2 frame_done pulses, each after windows 4 and 8.
- Feed windows into the comparator for frame 1..16 -> pooled outputs 6, 8, 14, 16.

Source files
------------

// File: rtl/pool_window_gen.sv
// Purpose    : 2x2 stride-2 window generator feeding the max-pool comparator; buffers one even row.
// Latency    : win_valid rises one cycle after the bottom-right pixel of a window is accepted.
// Backpressure: pix_ready = !win_valid || win_ready; input stalls only while a window is held.
//
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   pix_in/pix_valid/pix_ready   raster-order pixel stream in
//   win_out/win_valid/win_ready  2x2 window out ([0][0] TL, [0][1] TR, [1][0] BL, [1][1] BR)
//   frame_done            one-cycle pulse when the last window of a frame is accepted
// Optional: define POOL_WINDOW_POS_EN to add win_row/win_col (pooled-output coordinates of win_out).
module pool_window_gen #(
   parameter int DATA_WIDTH = 8,
   parameter int IMG_WIDTH  = 8,
   parameter int IMG_HEIGHT = 8,
   localparam int POS_W = $clog2(((IMG_WIDTH > IMG_HEIGHT) ? IMG_WIDTH : IMG_HEIGHT) / 2 + 1)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [DATA_WIDTH-1:0]            pix_in,
   input  logic                             pix_valid,
   output logic                             pix_ready,
   output logic [1:0][1:0][DATA_WIDTH-1:0]  win_out,
   output logic                             win_valid,
   input  logic                             win_ready,
`ifdef POOL_WINDOW_POS_EN
   output logic [POS_W-1:0]                 win_row,
   output logic [POS_W-1:0]                 win_col,
`endif
   output logic                             frame_done
);

   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);

   localparam logic [CW-1:0] COL_LAST     = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST     = RW'(IMG_HEIGHT - 1);
   // Last row/column that completes a window; a trailing odd row/column never does.
   localparam logic [CW-1:0] COL_LAST_WIN = CW'((IMG_WIDTH / 2) * 2 - 1);
   localparam logic [RW-1:0] ROW_LAST_WIN = RW'((IMG_HEIGHT / 2) * 2 - 1);

   localparam logic [0:0] S_EVEN = 1'b0;
   localparam logic [0:0] S_ODD  = 1'b1;

   logic [0:0]            state;
   logic [CW-1:0]         col;
   logic [RW-1:0]         row;
   logic [DATA_WIDTH-1:0] line_buf [IMG_WIDTH];
   logic [DATA_WIDTH-1:0] left_reg;
   logic                  win_last;

   logic          accept;
   logic          col_end;
   logic          row_end;
   logic          load_win;
   logic [CW-1:0] col_prev;

   assign pix_ready  = !win_valid || win_ready;
   assign accept     = pix_valid && pix_ready;
   assign col_end    = (col == COL_LAST);
   assign row_end    = (row == ROW_LAST);
   assign load_win   = accept && (state == S_ODD) && col[0];
   assign col_prev   = col - CW'(1);
   assign frame_done = win_valid && win_ready && win_last;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_EVEN;
         col       <= '0;
         row       <= '0;
         win_valid <= 1'b0;
         win_out   <= '0;
         win_last  <= 1'b0;
`ifdef POOL_WINDOW_POS_EN
         win_row   <= '0;
         win_col   <= '0;
`endif
      end else begin
         if (accept) begin
            if (col_end) begin
               col <= '0;
               if (row_end) begin
                  // Frame wrap always restarts on an even row, even for odd heights.
                  row   <= '0;
                  state <= S_EVEN;
               end else begin
                  row   <= row + RW'(1);
                  state <= (state == S_EVEN) ? S_ODD : S_EVEN;
               end
            end else begin
               col <= col + CW'(1);
            end
         end

         // A load in the same cycle as the downstream take keeps win_valid high.
         if (load_win) begin
            win_valid     <= 1'b1;
            win_out[0][0] <= line_buf[col_prev];
            win_out[0][1] <= line_buf[col];
            win_out[1][0] <= left_reg;
            win_out[1][1] <= pix_in;
            win_last      <= (row == ROW_LAST_WIN) && (col == COL_LAST_WIN);
`ifdef POOL_WINDOW_POS_EN
            win_row       <= POS_W'(row >> 1);
            win_col       <= POS_W'(col >> 1);
`endif
         end else if (win_ready) begin
            win_valid <= 1'b0;
         end
      end
   end

   // Data-only storage: contents are don't-care after reset, so no reset branch.
   always_ff @(posedge clk) begin
      if (accept && (state == S_EVEN)) begin
         line_buf[col] <= pix_in;
      end
      // A trailing even column of an odd-width row lands here too but is never used.
      if (accept && (state == S_ODD) && !col[0]) begin
         left_reg <= pix_in;
      end
   end

endmodule
